// File: rtl/control_defs.sv
// Shared encodings for the hardwired control sequencer: FSM states, opcodes,
// IR field positions and the strobe bundle driven toward the datapath.
package control_defs;

    localparam int OPC_W  = 5;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_e;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic alu3;
        logic muldiv;
        logic unary;
        logic nop;
        logic halt;
    } op_class_t;

    typedef struct packed {
        logic             pc_out;
        logic             pc_in;
        logic             inc_pc;
        logic             mar_in;
        logic             read;
        logic             mdr_in;
        logic             mdr_out;
        logic             ir_in;
        logic             y_in;
        logic             z_in;
        logic             zlo_out;
        logic             zhi_out;
        logic             hi_in;
        logic             lo_in;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             r_in;
        logic             r_out;
        logic [OPC_W-1:0] alu_op;
        logic             run;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = {$bits(ctrl_t){1'b0}};

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier; anything not recognised is treated as a nop.
module opcode_class_decode
    import control_defs::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class
);

    // Map each opcode onto exactly one execution class
    always_comb begin
        op_class = '{alu3: 1'b0, muldiv: 1'b0, unary: 1'b0, nop: 1'b0, halt: 1'b0};
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class.alu3   = 1'b1;
            OP_MUL, OP_DIV:                   op_class.muldiv = 1'b1;
            OP_NEG, OP_NOT:                   op_class.unary  = 1'b1;
            OP_HALT:                          op_class.halt   = 1'b1;
            default:                          op_class.nop    = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, opcode-driven execute in T3-T6,
// Moore strobes decoded from the state register.
module control_sequencer
    import control_defs::*;
#(
    parameter int IR_WIDTH = 32,
    parameter int OP_WIDTH = 5
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Stop,
    input  logic [IR_WIDTH-1:0] IR,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                HIin,
    output logic                LOin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [OP_WIDTH-1:0] AluOp,
    output logic                Run,
    output logic [3:0]          State
);

    state_e           state_r;
    state_e           state_next_s;
    logic             stop_pend_r;
    logic [OPC_W-1:0] opcode_s;
    op_class_t        op_class_s;
    ctrl_t            ctrl_s;
    logic             unused_ir_s;

    assign opcode_s    = IR[IR_WIDTH-1 -: OPC_W];
    assign unused_ir_s = ^IR[IR_WIDTH-OPC_W-1:0];

    opcode_class_decode u_decode (
        .opcode   (opcode_s),
        .op_class (op_class_s)
    );

    // State register; Reset returns the sequencer to RST immediately
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Remember a Stop seen mid-instruction so HALT is taken at the next T0
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stop_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6: stop_pend_r <= stop_pend_r | Stop;
                default:                                  stop_pend_r <= 1'b0;
            endcase
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_next_s = state_r;
        ctrl_s       = CTRL_NONE;
        case (state_r)
            ST_RST: begin
                ctrl_s.run   = Reset;
                state_next_s = ST_T0;
            end
            ST_T0: begin
                ctrl_s.run    = 1'b1;
                ctrl_s.pc_out = 1'b1;
                ctrl_s.mar_in = 1'b1;
                ctrl_s.inc_pc = 1'b1;
                ctrl_s.z_in   = 1'b1;
                if (Stop || stop_pend_r) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_T1;
                end
            end
            ST_T1: begin
                ctrl_s.run     = 1'b1;
                ctrl_s.zlo_out = 1'b1;
                ctrl_s.pc_in   = 1'b1;
                ctrl_s.read    = 1'b1;
                ctrl_s.mdr_in  = 1'b1;
                state_next_s   = ST_T2;
            end
            ST_T2: begin
                ctrl_s.run     = 1'b1;
                ctrl_s.mdr_out = 1'b1;
                ctrl_s.ir_in   = 1'b1;
                state_next_s   = ST_T3;
            end
            ST_T3: begin
                ctrl_s.run = 1'b1;
                if (op_class_s.alu3) begin
                    ctrl_s.grb   = 1'b1;
                    ctrl_s.r_out = 1'b1;
                    ctrl_s.y_in  = 1'b1;
                    state_next_s = ST_T4;
                end else if (op_class_s.muldiv) begin
                    ctrl_s.gra   = 1'b1;
                    ctrl_s.r_out = 1'b1;
                    ctrl_s.y_in  = 1'b1;
                    state_next_s = ST_T4;
                end else if (op_class_s.unary) begin
                    ctrl_s.grb    = 1'b1;
                    ctrl_s.r_out  = 1'b1;
                    ctrl_s.z_in   = 1'b1;
                    ctrl_s.alu_op = opcode_s;
                    state_next_s  = ST_T4;
                end else if (op_class_s.halt) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_T0;
                end
            end
            ST_T4: begin
                ctrl_s.run = 1'b1;
                if (op_class_s.alu3 || op_class_s.muldiv) begin
                    ctrl_s.grc    = op_class_s.alu3;
                    ctrl_s.grb    = op_class_s.muldiv;
                    ctrl_s.r_out  = 1'b1;
                    ctrl_s.z_in   = 1'b1;
                    ctrl_s.alu_op = opcode_s;
                    state_next_s  = ST_T5;
                end else if (op_class_s.unary) begin
                    ctrl_s.zlo_out = 1'b1;
                    ctrl_s.gra     = 1'b1;
                    ctrl_s.r_in    = 1'b1;
                    state_next_s   = ST_T0;
                end else begin
                    state_next_s = ST_T0;
                end
            end
            ST_T5: begin
                ctrl_s.run = 1'b1;
                if (op_class_s.alu3) begin
                    ctrl_s.zlo_out = 1'b1;
                    ctrl_s.gra     = 1'b1;
                    ctrl_s.r_in    = 1'b1;
                    state_next_s   = ST_T0;
                end else if (op_class_s.muldiv) begin
                    ctrl_s.zlo_out = 1'b1;
                    ctrl_s.lo_in   = 1'b1;
                    state_next_s   = ST_T6;
                end else begin
                    state_next_s = ST_T0;
                end
            end
            ST_T6: begin
                ctrl_s.run     = 1'b1;
                ctrl_s.zhi_out = op_class_s.muldiv;
                ctrl_s.hi_in   = op_class_s.muldiv;
                state_next_s   = ST_T0;
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_RST;
            end
        endcase
    end

    assign PCout  = ctrl_s.pc_out;
    assign PCin   = ctrl_s.pc_in;
    assign IncPC  = ctrl_s.inc_pc;
    assign MARin  = ctrl_s.mar_in;
    assign Read   = ctrl_s.read;
    assign MDRin  = ctrl_s.mdr_in;
    assign MDRout = ctrl_s.mdr_out;
    assign IRin   = ctrl_s.ir_in;
    assign Yin    = ctrl_s.y_in;
    assign Zin    = ctrl_s.z_in;
    assign ZLOout = ctrl_s.zlo_out;
    assign ZHIout = ctrl_s.zhi_out;
    assign HIin   = ctrl_s.hi_in;
    assign LOin   = ctrl_s.lo_in;
    assign Gra    = ctrl_s.gra;
    assign Grb    = ctrl_s.grb;
    assign Grc    = ctrl_s.grc;
    assign Rin    = ctrl_s.r_in;
    assign Rout   = ctrl_s.r_out;
    assign AluOp  = ctrl_s.alu_op;
    assign Run    = ctrl_s.run;
    assign State  = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus hand-written
// sequences for Stop at T0, the halt opcode and Reset in the middle of a mul.
module tb_control_sequencer;

    logic        Clock, Reset, Stop;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, ZLOout, ZHIout, HIin, LOin;
    logic        Gra, Grb, Grc, Rin, Rout, Run;
    logic [4:0]  AluOp;
    logic [3:0]  State;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .AluOp(AluOp), .Run(Run), .State(State)
    );

    localparam logic [19:0] S_PCOUT  = 20'd1 << 19;
    localparam logic [19:0] S_PCIN   = 20'd1 << 18;
    localparam logic [19:0] S_INCPC  = 20'd1 << 17;
    localparam logic [19:0] S_MARIN  = 20'd1 << 16;
    localparam logic [19:0] S_READ   = 20'd1 << 15;
    localparam logic [19:0] S_MDRIN  = 20'd1 << 14;
    localparam logic [19:0] S_MDROUT = 20'd1 << 13;
    localparam logic [19:0] S_IRIN   = 20'd1 << 12;
    localparam logic [19:0] S_YIN    = 20'd1 << 11;
    localparam logic [19:0] S_ZIN    = 20'd1 << 10;
    localparam logic [19:0] S_ZLO    = 20'd1 << 9;
    localparam logic [19:0] S_ZHI    = 20'd1 << 8;
    localparam logic [19:0] S_HIIN   = 20'd1 << 7;
    localparam logic [19:0] S_LOIN   = 20'd1 << 6;
    localparam logic [19:0] S_GRA    = 20'd1 << 5;
    localparam logic [19:0] S_GRB    = 20'd1 << 4;
    localparam logic [19:0] S_GRC    = 20'd1 << 3;
    localparam logic [19:0] S_RIN    = 20'd1 << 2;
    localparam logic [19:0] S_ROUT   = 20'd1 << 1;
    localparam logic [19:0] S_RUN    = 20'd1;

    localparam logic [19:0] V_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_RUN;
    localparam logic [19:0] V_T1 = S_ZLO | S_PCIN | S_READ | S_MDRIN | S_RUN;
    localparam logic [19:0] V_T2 = S_MDROUT | S_IRIN | S_RUN;

    localparam logic [31:0] NOP_IR  = 32'hD000_0000;
    localparam logic [31:0] ADD_IR  = 32'h1891_8000;
    localparam logic [31:0] MUL_IR  = 32'h8091_8000;
    localparam logic [31:0] NEG_IR  = 32'h8890_0000;
    localparam logic [31:0] UND_IR  = 32'h6000_0000;
    localparam logic [31:0] HALT_IR = 32'hD800_0000;

    typedef struct {
        logic [31:0] ir;
        logic        stop;
        logic [3:0]  st;
        logic [19:0] strobes;
        logic [4:0]  alu;
    } vec_t;

    vec_t        vecs[$];
    int          checks   = 0;
    int          failures = 0;
    int          bus_viol = 0;
    logic [19:0] obs_s;

    assign obs_s = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                    ZLOout, ZHIout, HIin, LOin, Gra, Grb, Grc, Rin, Rout, Run};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Single-bus and HI/LO exclusivity watched on every cycle
    always @(negedge Clock) begin
        if ($countones({PCout, ZLOout, ZHIout, MDRout, Rout}) > 1 || (HIin && LOin))
            bus_viol = bus_viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] ir, input logic stop, input logic [3:0] st,
                           input logic [19:0] strobes, input logic [4:0] alu);
        vec_t v;
        v.ir = ir; v.stop = stop; v.st = st; v.strobes = strobes; v.alu = alu;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Stop  = 1'b0;
        @(negedge Clock);
        #1;
        check("rst_state", {28'd0, State}, 32'd0);
        check("rst_outs", {7'd0, obs_s, AluOp}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("rst_rel_state", {28'd0, State}, 32'd0);
        check("rst_rel_outs", {7'd0, obs_s, AluOp}, {7'd0, S_RUN, 5'd0});
    endtask

    initial begin
        IR    = NOP_IR;
        Stop  = 1'b0;
        Reset = 1'b0;

        // nop
        add_vec(NOP_IR, 1'b0, 4'd1, V_T0, 5'd0);
        add_vec(NOP_IR, 1'b0, 4'd2, V_T1, 5'd0);
        add_vec(NOP_IR, 1'b0, 4'd3, V_T2, 5'd0);
        add_vec(NOP_IR, 1'b0, 4'd4, S_RUN, 5'd0);
        add_vec(NOP_IR, 1'b0, 4'd1, V_T0, 5'd0);
        // add R1,R2,R3 loaded during T2
        add_vec(NOP_IR, 1'b0, 4'd2, V_T1, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd3, V_T2, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd4, S_GRB | S_ROUT | S_YIN | S_RUN, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd5, S_GRC | S_ROUT | S_ZIN | S_RUN, 5'b00011);
        add_vec(ADD_IR, 1'b0, 4'd6, S_ZLO | S_GRA | S_RIN | S_RUN, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd1, V_T0, 5'd0);
        // mul R1,R2
        add_vec(MUL_IR, 1'b0, 4'd2, V_T1, 5'd0);
        add_vec(MUL_IR, 1'b0, 4'd3, V_T2, 5'd0);
        add_vec(MUL_IR, 1'b0, 4'd4, S_GRA | S_ROUT | S_YIN | S_RUN, 5'd0);
        add_vec(MUL_IR, 1'b0, 4'd5, S_GRB | S_ROUT | S_ZIN | S_RUN, 5'b10000);
        add_vec(MUL_IR, 1'b0, 4'd6, S_ZLO | S_LOIN | S_RUN, 5'd0);
        add_vec(MUL_IR, 1'b0, 4'd7, S_ZHI | S_HIIN | S_RUN, 5'd0);
        add_vec(MUL_IR, 1'b0, 4'd1, V_T0, 5'd0);
        // neg R1,R2
        add_vec(NEG_IR, 1'b0, 4'd2, V_T1, 5'd0);
        add_vec(NEG_IR, 1'b0, 4'd3, V_T2, 5'd0);
        add_vec(NEG_IR, 1'b0, 4'd4, S_GRB | S_ROUT | S_ZIN | S_RUN, 5'b10001);
        add_vec(NEG_IR, 1'b0, 4'd5, S_ZLO | S_GRA | S_RIN | S_RUN, 5'd0);
        add_vec(NEG_IR, 1'b0, 4'd1, V_T0, 5'd0);
        // undefined opcode behaves as nop
        add_vec(UND_IR, 1'b0, 4'd2, V_T1, 5'd0);
        add_vec(UND_IR, 1'b0, 4'd3, V_T2, 5'd0);
        add_vec(UND_IR, 1'b0, 4'd4, S_RUN, 5'd0);
        add_vec(UND_IR, 1'b0, 4'd1, V_T0, 5'd0);
        // add with Stop pulsed in T4: completes, then HALT from the next T0
        add_vec(ADD_IR, 1'b0, 4'd2, V_T1, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd3, V_T2, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd4, S_GRB | S_ROUT | S_YIN | S_RUN, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd5, S_GRC | S_ROUT | S_ZIN | S_RUN, 5'b00011);
        add_vec(ADD_IR, 1'b1, 4'd6, S_ZLO | S_GRA | S_RIN | S_RUN, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd1, V_T0, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd8, 20'd0, 5'd0);
        add_vec(ADD_IR, 1'b1, 4'd8, 20'd0, 5'd0);
        add_vec(ADD_IR, 1'b0, 4'd8, 20'd0, 5'd0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            IR   = vecs[i].ir;
            Stop = vecs[i].stop;
            step();
            check($sformatf("vec%0d_state", i), {28'd0, State}, {28'd0, vecs[i].st});
            check($sformatf("vec%0d_outs", i), {7'd0, obs_s, AluOp},
                  {7'd0, vecs[i].strobes, vecs[i].alu});
        end

        // Stop sampled at the T0 edge: no fetch, straight to HALT
        do_reset();
        Stop = 1'b1;
        step();
        check("stop_t0_state", {28'd0, State}, 32'd1);
        step();
        check("stop_halt_state", {28'd0, State}, 32'd8);
        check("stop_halt_outs", {7'd0, obs_s, AluOp}, 32'd0);
        Stop = 1'b0;
        step();
        check("stop_halt_hold", {28'd0, State}, 32'd8);

        // halt opcode: T3 -> HALT
        do_reset();
        IR = HALT_IR;
        for (int i = 0; i < 4; i++) step();
        check("halt_t3_state", {28'd0, State}, 32'd4);
        check("halt_t3_outs", {7'd0, obs_s, AluOp}, {7'd0, S_RUN, 5'd0});
        step();
        check("halt_op_state", {28'd0, State}, 32'd8);
        check("halt_op_run", {31'd0, Run}, 32'd0);

        // Reset for half a cycle during T4 of mul
        do_reset();
        IR = MUL_IR;
        for (int i = 0; i < 5; i++) step();
        check("mulrst_t4_state", {28'd0, State}, 32'd5);
        check("mulrst_t4_alu", {27'd0, AluOp}, 32'd16);
        Reset = 1'b0;
        #1;
        check("mulrst_state", {28'd0, State}, 32'd0);
        check("mulrst_outs", {7'd0, obs_s, AluOp}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        IR    = NOP_IR;
        step();
        check("mulrst_t0_state", {28'd0, State}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mulrst_hilo%0d", i), {30'd0, HIin, LOin}, 32'd0);
            step();
        end
        check("mulrst_resume_state", {28'd0, State}, 32'd1);

        check("bus_exclusive", bus_viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
